// File: rtl/spi_target_pkg.sv
// rtl/spi_target_pkg.sv - shared state encoding, register addresses and frame sizes
package spi_target_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CMD  = 2'd1,
    ST_DATA = 2'd2,
    ST_DONE = 2'd3
  } state_t;

  localparam logic [6:0] ADDR_LED     = 7'h00;
  localparam logic [6:0] ADDR_BTN     = 7'h01;
  localparam logic [6:0] ADDR_SCRATCH = 7'h02;
  localparam logic [6:0] ADDR_ID      = 7'h03;
  localparam logic [6:0] ADDR_FCNT    = 7'h04;

  localparam int FRAME_BITS = 16;
  localparam int CMD_BITS   = 8;

endpackage

// File: rtl/spi_in_sync.sv
// rtl/spi_in_sync.sv - oversampling synchroniser for SPI pins and buttons, with sclk edge detect
module spi_in_sync #(
  parameter int SYNC_STAGES = 2,
  parameter int BTN_WIDTH   = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 sclk,
  input  logic                 ss_n,
  input  logic                 mosi,
  input  logic [BTN_WIDTH-1:0] butons,
  output logic                 sclk_rise,
  output logic                 sclk_fall,
  output logic                 ss_n_sync,
  output logic                 mosi_sync,
  output logic [BTN_WIDTH-1:0] btn_sync
);

  logic [SYNC_STAGES-1:0]                sclk_q;
  logic [SYNC_STAGES-1:0]                ss_q;
  logic [SYNC_STAGES-1:0]                mosi_q;
  logic [SYNC_STAGES-1:0][BTN_WIDTH-1:0] btn_q;
  logic                                  sclk_hist;

  // ss_n chain clears to 0 so a select held low across reset is not mistaken for a fresh idle period
  always_ff @(posedge clk) begin
    if (rst) begin
      sclk_q    <= '0;
      ss_q      <= '0;
      mosi_q    <= '0;
      btn_q     <= '0;
      sclk_hist <= 1'b0;
    end else begin
      sclk_q    <= {sclk_q[SYNC_STAGES-2:0], sclk};
      ss_q      <= {ss_q[SYNC_STAGES-2:0], ss_n};
      mosi_q    <= {mosi_q[SYNC_STAGES-2:0], mosi};
      btn_q     <= {btn_q[SYNC_STAGES-2:0], butons};
      sclk_hist <= sclk_q[SYNC_STAGES-1];
    end
  end

  assign sclk_rise = sclk_q[SYNC_STAGES-1] & ~sclk_hist;
  assign sclk_fall = ~sclk_q[SYNC_STAGES-1] & sclk_hist;
  assign ss_n_sync = ss_q[SYNC_STAGES-1];
  assign mosi_sync = mosi_q[SYNC_STAGES-1];
  assign btn_sync  = btn_q[SYNC_STAGES-1];

endmodule

// File: rtl/spi_target_regs.sv
// rtl/spi_target_regs.sv - SPI mode-0 target exposing LED, button, scratch, ID and frame-count registers
import spi_target_pkg::*;

module spi_target_regs #(
  parameter int                   SYNC_STAGES = 2,
  parameter int                   LED_WIDTH   = 4,
  parameter int                   BTN_WIDTH   = 2,
  parameter logic [7:0]           ID_VALUE    = 8'hA5,
  parameter logic [LED_WIDTH-1:0] LED_RESET   = '0
) (
  input  logic                 io_systemClk,
  input  logic                 io_systemReset,
  input  logic                 spi_sclk,
  input  logic                 spi_ss_n,
  input  logic                 spi_mosi,
  output logic                 spi_miso,
  output logic                 spi_miso_oe,
  input  logic [BTN_WIDTH-1:0] butons,
  output logic [LED_WIDTH-1:0] leds,
  output logic                 frame_done
);

  localparam logic [4:0] CMD_LAST   = 5'(CMD_BITS - 1);
  localparam logic [4:0] FRAME_LAST = 5'(FRAME_BITS - 1);
  localparam logic [4:0] TX_FIRST   = 5'(CMD_BITS + 1);

  logic                 sclk_rise;
  logic                 sclk_fall;
  logic                 ss_n_sync;
  logic                 mosi_sync;
  logic [BTN_WIDTH-1:0] btn_sync;

  spi_in_sync #(
    .SYNC_STAGES(SYNC_STAGES),
    .BTN_WIDTH  (BTN_WIDTH)
  ) u_sync (
    .clk      (io_systemClk),
    .rst      (io_systemReset),
    .sclk     (spi_sclk),
    .ss_n     (spi_ss_n),
    .mosi     (spi_mosi),
    .butons   (butons),
    .sclk_rise(sclk_rise),
    .sclk_fall(sclk_fall),
    .ss_n_sync(ss_n_sync),
    .mosi_sync(mosi_sync),
    .btn_sync (btn_sync)
  );

  state_t               state;
  state_t               state_next;
  logic [4:0]           bit_cnt;
  logic [6:0]           rx_shift;
  logic [7:0]           tx_shift;
  logic                 rw;
  logic [6:0]           addr;
  logic                 armed;
  logic                 wr_led;
  logic                 wr_scratch;
  logic [7:0]           wr_data;
  logic [LED_WIDTH-1:0] led_reg;
  logic [7:0]           scratch;
  logic [7:0]           fcnt;
  logic                 miso_oe;
  logic                 done_pulse;

  logic                 start;
  logic                 abort;
  logic                 leave_done;
  logic                 rx_shift_en;
  logic                 cmd_last;
  logic                 data_last;
  logic                 tx_shift_en;
  logic [7:0]           rx_byte;
  logic [7:0]           rd_data;

  // Byte completed by the current rise: seven bits already held plus the bit being sampled now
  assign rx_byte = {rx_shift, mosi_sync};

  always_ff @(posedge io_systemClk) begin
    if (io_systemReset) begin
      state <= ST_IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next  = state;
    start       = 1'b0;
    abort       = 1'b0;
    leave_done  = 1'b0;
    rx_shift_en = 1'b0;
    cmd_last    = 1'b0;
    data_last   = 1'b0;
    tx_shift_en = 1'b0;
    case (state)
      ST_IDLE: begin
        if (armed && !ss_n_sync) begin
          start      = 1'b1;
          state_next = ST_CMD;
        end
      end
      ST_CMD: begin
        if (ss_n_sync) begin
          abort      = 1'b1;
          state_next = ST_IDLE;
        end else if (sclk_rise) begin
          rx_shift_en = 1'b1;
          if (bit_cnt == CMD_LAST) begin
            cmd_last   = 1'b1;
            state_next = ST_DATA;
          end
        end
      end
      ST_DATA: begin
        if (ss_n_sync) begin
          abort      = 1'b1;
          state_next = ST_IDLE;
        end else begin
          if (sclk_rise) begin
            rx_shift_en = 1'b1;
            if (bit_cnt == FRAME_LAST) begin
              data_last  = 1'b1;
              state_next = ST_DONE;
            end
          end
          // The fall right after the command byte keeps the MSB on the line for rise 9
          if (sclk_fall && bit_cnt >= TX_FIRST) begin
            tx_shift_en = 1'b1;
          end
        end
      end
      ST_DONE: begin
        if (ss_n_sync) begin
          leave_done = 1'b1;
          state_next = ST_IDLE;
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  always_comb begin
    rd_data = 8'h00;
    case (rx_byte[6:0])
      ADDR_LED:     rd_data[LED_WIDTH-1:0] = led_reg;
      ADDR_BTN:     rd_data[BTN_WIDTH-1:0] = btn_sync;
      ADDR_SCRATCH: rd_data = scratch;
      ADDR_ID:      rd_data = ID_VALUE;
      ADDR_FCNT:    rd_data = fcnt;
      default:      rd_data = 8'h00;
    endcase
  end

  always_ff @(posedge io_systemClk) begin
    if (io_systemReset) begin
      bit_cnt    <= '0;
      rx_shift   <= '0;
      tx_shift   <= '0;
      rw         <= 1'b0;
      addr       <= '0;
      armed      <= 1'b0;
      wr_led     <= 1'b0;
      wr_scratch <= 1'b0;
      wr_data    <= '0;
      led_reg    <= LED_RESET;
      scratch    <= '0;
      fcnt       <= '0;
      miso_oe    <= 1'b0;
      done_pulse <= 1'b0;
    end else begin
      done_pulse <= data_last;
      wr_led     <= 1'b0;
      wr_scratch <= 1'b0;

      // A new frame needs ss_n observed high since the last one started (or since reset)
      if (start) begin
        armed <= 1'b0;
      end else if (ss_n_sync) begin
        armed <= 1'b1;
      end

      if (start) begin
        bit_cnt <= '0;
        miso_oe <= 1'b1;
      end
      if (abort || leave_done) begin
        miso_oe <= 1'b0;
      end

      if (rx_shift_en) begin
        rx_shift <= rx_byte[6:0];
        bit_cnt  <= bit_cnt + 5'd1;
      end

      if (cmd_last) begin
        rw       <= rx_byte[7];
        addr     <= rx_byte[6:0];
        tx_shift <= rx_byte[7] ? rd_data : 8'h00;
      end else if (tx_shift_en) begin
        tx_shift <= {tx_shift[6:0], 1'b0};
      end

      if (data_last) begin
        fcnt       <= fcnt + 8'd1;
        wr_data    <= rx_byte;
        wr_led     <= !rw && (addr == ADDR_LED);
        wr_scratch <= !rw && (addr == ADDR_SCRATCH);
      end

      if (wr_led) begin
        led_reg <= wr_data[LED_WIDTH-1:0];
      end
      if (wr_scratch) begin
        scratch <= wr_data;
      end
    end
  end

  assign spi_miso    = (state == ST_DATA) && rw && tx_shift[7];
  assign spi_miso_oe = miso_oe;
  assign leds        = led_reg;
  assign frame_done  = done_pulse;

endmodule

// File: doc/spi_target_regs.md
Name: spi_target_regs

Overview:
- SPI target (slave) in fabric that answers the SoC's system_spi_0 controller.
- Gives firmware a small register map: LED drive, button readback, scratch, ID, frame counter.
- All SPI inputs are oversampled in the io_systemClk domain; the block contains no SCLK-clocked logic.
- Sits between the SoC SPI pins (data_0 = MOSI, data_1 = MISO) and the board leds/butons.

Parameters:
- SYNC_STAGES, 2, synchroniser depth on spi_sclk/spi_ss_n/spi_mosi (legal range 2–3)
- LED_WIDTH, 4, width of leds output and LED register
- BTN_WIDTH, 2, width of butons input
- ID_VALUE, 8'hA5, constant returned by the ID register
- LED_RESET, 0, reset value of the LED register

Ports:
- io_systemClk  input  1  system clock; all logic is on its rising edge
- io_systemReset  input  1  synchronous, active-high reset
- spi_sclk  input  1  SPI clock from controller, mode 0 (CPOL=0, CPHA=0); frequency ≤ io_systemClk/8
- spi_ss_n  input  1  chip select, active low
- spi_mosi  input  1  controller-to-target data (system_spi_0_io_data_0_write)
- spi_miso  output  1  target-to-controller data (system_spi_0_io_data_1_read)
- spi_miso_oe  output  1  high while a frame is active
- butons  input  BTN_WIDTH  raw buttons; synchronised internally
- leds  output  LED_WIDTH  LED register contents
- frame_done  output  1  one-cycle pulse at the end of each complete 16-bit frame

Behaviour:
- Reset (synchronous, io_systemReset=1):
  - leds=LED_RESET, spi_miso=0, spi_miso_oe=0, frame_done=0
  - scratch=0, frame counter=0, FSM=IDLE, bit count=0, shift registers cleared
- Synchronisation and edge detection:
  - SYNC_STAGES flops on each SPI input, plus one history flop on sclk.
  - rise = sync & ~hist; fall = ~sync & hist.
  - Latency from a pin edge to internal detection is SYNC_STAGES+1 cycles.
- Frame format, MSB first, 16 bits:
  - Byte 0 = {rw, addr[6:0]}; rw=1 is a read.
  - Byte 1 = write data, or read data returned on MISO.
- FSM states:
  - IDLE: ss_n synced low → CMD, count=0, miso_oe=1.
  - CMD: shift MOSI in on each rise. After the 8th rise, latch rw/addr. For a read, load the read byte into the TX shifter and drive its MSB on spi_miso on the next cycle. → DATA.
  - DATA:
    - MOSI is shifted in on each rise.
    - MISO shifts on falling edges 9..15 of the frame; falling edge 8 is ignored.
    - After the 16th rise, for a write with addr 0x00 or 0x02, update the register on the following cycle.
    - Pulse frame_done and increment the frame counter. → DONE.
  - DONE: ignore all further edges; ss_n synced high → IDLE, miso_oe=0, miso=0.
- Register map (reads return 8 bits, zero-extended):
  - 0x00 LED: RW, low LED_WIDTH bits.
  - 0x01 buttons: RO, synchronised butons.
  - 0x02 scratch: RW, 8 bits.
  - 0x03 ID: RO, ID_VALUE.
  - 0x04 frame counter: RO, 8 bits, wraps 0xFF→0x00.
  - 0x05–0x7F read as 0x00.
  - Writes to RO or unmapped addresses are discarded but still count as a frame.
- Read data is a snapshot taken at the 8th rise. The frame counter reads its pre-increment value.
- spi_miso is 0 during the command byte and whenever the FSM is not in DATA with rw=1.
- Boundary conditions:
  - ss_n deasserted in CMD or DATA before the 16th rise: abort → IDLE. No register write, no frame_done, no counter increment.
  - ss_n low again right after an abort or DONE: a new frame starts only after ss_n has been seen high for ≥1 cycle.
  - Reset asserted mid-frame: immediate return to reset state. A frame in progress is lost; the FSM waits for ss_n high before accepting a new frame.
  - sclk edges while ss_n is high are ignored.

Decomposition:
- Shared package spi_target_pkg holds:
  - state encoding (IDLE, CMD, DATA, DONE)
  - address constants (ADDR_LED=0, ADDR_BTN=1, ADDR_SCRATCH=2, ADDR_ID=3, ADDR_FCNT=4)
  - FRAME_BITS=16, CMD_BITS=8
- One natural sub-module: spi_in_sync, the parameterised multi-bit synchroniser with sclk edge detect.

Test Plan:
- Write LED: frame 0x00,0x05 → leds=4'b0101 one cycle after the 16th rise; frame_done pulses once.
- Read ID: frame 0x83,0x00 → MISO byte1 = 0xA5 sampled on rises 9–16; spi_miso=0 during byte 0.
- Scratch round-trip: write 0x02,0x3C, then read 0x82 → returns 0x3C. Then read 0x84 → returns 0x02 (two prior frames).
- Abort: ss_n raised after 11 rises of a write 0x00,0xFF → leds unchanged, no frame_done, counter unchanged.
- Buttons and unmapped: butons=2'b10, read 0x81 → 0x02. Read 0x90 → 0x00. Write 0x03,0x00 → ID still 0xA5, counter increments.
- Reset mid-DATA: assert io_systemReset at rise 12 of a write → all outputs reset. ss_n held low afterwards produces no frame until ss_n goes high then low; a following write 0x00,0x0F → leds=4'hF.
